regfile_2r1w: RTL and testbench
===============================

Name: regfile_2r1w

Overview:
- Parametrised register file: one write port, two independent read ports with registered outputs.
- Same-cycle write-to-read bypass, optional hard-wired zero entry, and a sequenced clear-all operation.
- Generalises the 8x8 single-port register file. Drop-in operand store for datapath and accumulator blocks.

Parameters:
- DATA_W, 8, data width in bits.
- DEPTH, 8, number of entries (2..256; need not be a power of two).
- ADDR_W, $clog2(DEPTH), address width (derived; do not override).
- ZERO_REG, 0, when 1, entry 0 always reads 0 and ignores writes.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- we  input  1  write enable.
- wa  input  ADDR_W  write address.
- wd  input  DATA_W  write data.
- re0  input  1  read enable, port 0.
- ra0  input  ADDR_W  read address, port 0.
- rd0  output  DATA_W  registered read data, port 0.
- rv0  output  1  rd0 valid strobe.
- re1, ra1, rd1, rv1  as port 0, for port 1.
- clr  input  1  start clear-all sequence.
- busy  output  1  clear sequence in progress.

Behaviour:
- Reset (rst=1 at edge): all entries 0; rd0=rd1=0; rv0=rv1=0; busy=0; FSM to IDLE; clear counter 0. Overrides every other input, including mid-clear.
- FSM states: IDLE, CLEAR.
  - IDLE->CLEAR on clr=1; busy=1 from the next cycle.
  - In CLEAR, one entry is zeroed per cycle, counter 0..DEPTH-1.
  - Entry DEPTH-1 zeroed -> IDLE; busy=0 on the following cycle.
  - busy is high for exactly DEPTH cycles.
- Write: in IDLE, we=1 and clr=0 -> mem[wa]<=wd at the edge.
  - Ignored when wa>=DEPTH, or wa==0 with ZERO_REG=1.
- Read latency 1:
  - In IDLE with clr=0 and rePn=1, the next cycle gives rdn=mem[ran] and rvn=1.
  - Bypass: if the same cycle has we=1 and wa==ran (write legal), rdn=wd, not the old value.
  - ran>=DEPTH, or ran==0 with ZERO_REG=1, gives rdn=0 with rvn=1.
  - Both ports may read the same address in the same cycle; both return identical data.
- rePn=0: rvn=0 next cycle; rdn holds its previous value.
- clr priority: a cycle with clr=1 in IDLE ignores we, re0 and re1; rv0=rv1=0 next cycle.
- While busy=1: we, re0, re1 and clr are ignored; rv0=rv1=0; rd0/rd1 hold.
- Write and read of the same address in IDLE: the write commits and the read returns the new data (bypass). A read one cycle later also sees the new data.

Test Plan:
- rst, then read all 8 addresses on both ports with defaults -> every rd=0x00 with rv=1, one cycle after each re.
- Write 0xA5 to addr 3, then next cycle read addr 3 on port 0 and addr 3 on port 1 -> rd0=rd1=0xA5, rv0=rv1=1.
- Same cycle: we=1 wa=5 wd=0x3C, re0=1 ra0=5 -> next cycle rd0=0x3C (bypass). Port 1 reading addr 5 with old value 0x11 the cycle before -> 0x11.
- Fill entries with 0xFF, pulse clr with we=1 in the same cycle:
  - write ignored.
  - busy high exactly 8 cycles; re during busy gives rv=0.
  - afterwards all reads return 0x00.
- Assert rst at cycle 3 of a clear:
  - busy=0 next cycle.
  - all entries 0.
  - a new write of 0x77 to addr 7 then a read returns 0x77.
- ZERO_REG=1, DEPTH=6:
  - write 0x55 to addr 0 -> read returns 0x00.
  - read addr 7 -> 0x00 with rv=1.
  - write addr 6 is ignored.

Source files
------------

// File: rtl/regfile_2r1w_if.sv
// Bus bundle for regfile_2r1w: one write port, two read ports and the clear handshake.
interface regfile_2r1w_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              re0;
    logic [ADDR_W-1:0] ra0;
    logic [DATA_W-1:0] rd0;
    logic              rv0;
    logic              re1;
    logic [ADDR_W-1:0] ra1;
    logic [DATA_W-1:0] rd1;
    logic              rv1;
    logic              clr;
    logic              busy;

    modport master (
        output we, wa, wd, re0, ra0, re1, ra1, clr,
        input  rd0, rv0, rd1, rv1, busy
    );

    modport slave (
        input  we, wa, wd, re0, ra0, re1, ra1, clr,
        output rd0, rv0, rd1, rv1, busy
    );
endinterface

// File: rtl/regfile_2r1w.sv
// Parametrised 2-read/1-write register file with registered reads, same-cycle
// write bypass, optional hard-wired zero entry and a one-entry-per-cycle clear.
module regfile_2r1w #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter bit ZERO_REG = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    regfile_2r1w_if.slave    bus
);
    typedef enum logic {IDLE, CLEAR} state_e;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
    logic              rv0_q, rv0_d, rv1_q, rv1_d;
    logic              wr_en, rd0_en, rd1_en, clr_en;

    // Addresses beyond DEPTH (non power-of-two depths) and the zero entry are not storage.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_C) && !(ZERO_REG && (a == '0));
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (cnt_q == LAST_C) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        clr_en   = (state_q == CLEAR);
        wr_en    = (state_q == IDLE) && !bus.clr && bus.we && addr_ok(bus.wa);
        rd0_en   = (state_q == IDLE) && !bus.clr && bus.re0;
        rd1_en   = (state_q == IDLE) && !bus.clr && bus.re1;
        bus.busy = clr_en;
        bus.rd0  = rd0_q;
        bus.rv0  = rv0_q;
        bus.rd1  = rd1_q;
        bus.rv1  = rv1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else if (clr_en) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_en) begin
            mem_q[bus.wa] <= bus.wd;
        end
    end

    // Read data: illegal address gives zero, a matching legal write is forwarded.
    always_comb begin
        rd0_d = rd0_q;
        rv0_d = 1'b0;
        if (rd0_en) begin
            rv0_d = 1'b1;
            if (!addr_ok(bus.ra0))                  rd0_d = '0;
            else if (wr_en && (bus.wa == bus.ra0))  rd0_d = bus.wd;
            else                                    rd0_d = mem_q[bus.ra0];
        end
    end

    always_comb begin
        rd1_d = rd1_q;
        rv1_d = 1'b0;
        if (rd1_en) begin
            rv1_d = 1'b1;
            if (!addr_ok(bus.ra1))                  rd1_d = '0;
            else if (wr_en && (bus.wa == bus.ra1))  rd1_d = bus.wd;
            else                                    rd1_d = mem_q[bus.ra1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd0_q <= '0;
            rv0_q <= 1'b0;
            rd1_q <= '0;
            rv1_q <= 1'b0;
        end else begin
            rd0_q <= rd0_d;
            rv0_q <= rv0_d;
            rd1_q <= rd1_d;
            rv1_q <= rv1_d;
        end
    end
endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w: default 8x8 instance plus a ZERO_REG=1, DEPTH=6 instance.
module tb_regfile_2r1w;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   nbusy;

    always #5 clk = ~clk;

    regfile_2r1w_if #(.DATA_W(8), .ADDR_W(3)) bus0 ();
    regfile_2r1w_if #(.DATA_W(8), .ADDR_W(3)) bus1 ();

    regfile_2r1w #(.DATA_W(8), .DEPTH(8), .ZERO_REG(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    regfile_2r1w #(.DATA_W(8), .DEPTH(6), .ZERO_REG(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle0();
        bus0.we = 1'b0; bus0.wa = '0; bus0.wd = '0;
        bus0.re0 = 1'b0; bus0.ra0 = '0; bus0.re1 = 1'b0; bus0.ra1 = '0;
        bus0.clr = 1'b0;
    endtask

    task automatic idle1();
        bus1.we = 1'b0; bus1.wa = '0; bus1.wd = '0;
        bus1.re0 = 1'b0; bus1.ra0 = '0; bus1.re1 = 1'b0; bus1.ra1 = '0;
        bus1.clr = 1'b0;
    endtask

    task automatic wr0(input logic [2:0] a, input logic [7:0] d);
        bus0.we = 1'b1; bus0.wa = a; bus0.wd = d;
        step();
        bus0.we = 1'b0;
    endtask

    task automatic wr1(input logic [2:0] a, input logic [7:0] d);
        bus1.we = 1'b1; bus1.wa = a; bus1.wd = d;
        step();
        bus1.we = 1'b0;
    endtask

    task automatic rd_both0(input logic [2:0] a, input logic [7:0] exp, input string tag);
        bus0.re0 = 1'b1; bus0.ra0 = a; bus0.re1 = 1'b1; bus0.ra1 = a;
        step();
        check($sformatf("%s_rd0_a%0d", tag, a), bus0.rd0, exp);
        check($sformatf("%s_rv0_a%0d", tag, a), bus0.rv0, 1);
        check($sformatf("%s_rd1_a%0d", tag, a), bus0.rd1, exp);
        check($sformatf("%s_rv1_a%0d", tag, a), bus0.rv1, 1);
        bus0.re0 = 1'b0; bus0.re1 = 1'b0;
    endtask

    task automatic rd_both1(input logic [2:0] a, input logic [7:0] exp, input string tag);
        bus1.re0 = 1'b1; bus1.ra0 = a; bus1.re1 = 1'b1; bus1.ra1 = a;
        step();
        check($sformatf("%s_rd0_a%0d", tag, a), bus1.rd0, exp);
        check($sformatf("%s_rv0_a%0d", tag, a), bus1.rv0, 1);
        check($sformatf("%s_rd1_a%0d", tag, a), bus1.rd1, exp);
        check($sformatf("%s_rv1_a%0d", tag, a), bus1.rv1, 1);
        bus1.re0 = 1'b0; bus1.re1 = 1'b0;
    endtask

    initial begin
        idle0();
        idle1();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_rd0", bus0.rd0, 0);
        check("rst_rd1", bus0.rd1, 0);
        check("rst_rv0", bus0.rv0, 0);
        check("rst_rv1", bus0.rv1, 0);
        check("rst_busy", bus0.busy, 0);

        for (int a = 0; a < 8; a++) rd_both0(3'(a), 8'h00, "init");

        // Write then read on both ports
        wr0(3'd3, 8'hA5);
        rd_both0(3'd3, 8'hA5, "wr3");

        // Old value seen on port 1, bypass on port 0, hold on idle port 1
        wr0(3'd5, 8'h11);
        bus0.re1 = 1'b1; bus0.ra1 = 3'd5;
        step();
        check("old5_rd1", bus0.rd1, 8'h11);
        check("old5_rv1", bus0.rv1, 1);
        bus0.re1 = 1'b0;
        bus0.we = 1'b1; bus0.wa = 3'd5; bus0.wd = 8'h3C;
        bus0.re0 = 1'b1; bus0.ra0 = 3'd5;
        step();
        check("byp_rd0", bus0.rd0, 8'h3C);
        check("byp_rv0", bus0.rv0, 1);
        check("byp_rv1_off", bus0.rv1, 0);
        check("byp_rd1_hold", bus0.rd1, 8'h11);
        bus0.we = 1'b0;
        step();
        check("after_byp_rd0", bus0.rd0, 8'h3C);
        bus0.re0 = 1'b0;

        // Fill with FF, then clear with a competing write
        for (int a = 0; a < 8; a++) wr0(3'(a), 8'hFF);
        rd_both0(3'd6, 8'hFF, "fill");
        bus0.clr = 1'b1; bus0.we = 1'b1; bus0.wa = 3'd2; bus0.wd = 8'h5A;
        bus0.re0 = 1'b1; bus0.ra0 = 3'd6; bus0.re1 = 1'b1; bus0.ra1 = 3'd6;
        step();
        bus0.clr = 1'b0; bus0.wa = 3'd0; bus0.wd = 8'h99;
        nbusy = 0;
        for (int i = 0; i < 20; i++) begin
            if (!bus0.busy) break;
            nbusy++;
            check($sformatf("busy_rv0_c%0d", i), bus0.rv0, 0);
            check($sformatf("busy_rv1_c%0d", i), bus0.rv1, 0);
            step();
        end
        idle0();
        check("busy_cycles", nbusy, 8);
        check("clr_rd0_hold", bus0.rd0, 8'hFF);
        check("clr_rv0_end", bus0.rv0, 0);
        for (int a = 0; a < 8; a++) rd_both0(3'(a), 8'h00, "clr");

        // Reset in the middle of a clear
        wr0(3'd7, 8'h42);
        wr0(3'd1, 8'h24);
        bus0.clr = 1'b1;
        step();
        bus0.clr = 1'b0;
        check("mid_busy_on", bus0.busy, 1);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_busy", bus0.busy, 0);
        check("mid_rst_rd0", bus0.rd0, 0);
        for (int a = 0; a < 8; a++) rd_both0(3'(a), 8'h00, "midrst");
        wr0(3'd7, 8'h77);
        rd_both0(3'd7, 8'h77, "post");

        // ZERO_REG=1, DEPTH=6 instance
        wr1(3'd0, 8'h55);
        rd_both1(3'd0, 8'h00, "z0");
        rd_both1(3'd7, 8'h00, "oob7");
        wr1(3'd6, 8'h66);
        rd_both1(3'd6, 8'h00, "oob6");
        wr1(3'd5, 8'h5E);
        rd_both1(3'd5, 8'h5E, "last");
        bus1.we = 1'b1; bus1.wa = 3'd0; bus1.wd = 8'hAA;
        bus1.re0 = 1'b1; bus1.ra0 = 3'd0;
        step();
        check("z0_byp_rd0", bus1.rd0, 8'h00);
        check("z0_byp_rv0", bus1.rv0, 1);
        idle1();
        bus1.clr = 1'b1;
        step();
        bus1.clr = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 20; i++) begin
            if (!bus1.busy) break;
            nbusy++;
            step();
        end
        check("z_busy_cycles", nbusy, 6);
        rd_both1(3'd5, 8'h00, "zclr");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected completion");
        $fatal(1);
    end
endmodule
